// File: rtl/prog_loader.sv
// prog_loader: writer side of the program memory.
// Collects a length chunk, then P_K narrow chunks per control word (LSB chunk
// first), and writes each assembled word into the program memory. The CPU is
// held in reset until a complete program has been written.
module prog_loader #(
    parameter int P_LOG_MEMSIZE    = 4,
    parameter int P_NUM_D_CTRLBITS = 5,
    parameter int P_NUM_C_CTRLBITS = 2,
    parameter int P_IN_WIDTH       = 4,
    localparam int P_IW = P_NUM_D_CTRLBITS + P_NUM_C_CTRLBITS + P_LOG_MEMSIZE,
    localparam int P_K  = (P_IW + P_IN_WIDTH - 1) / P_IN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [P_IN_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [P_LOG_MEMSIZE-1:0] mem_addr,
    output logic [P_IW-1:0]          mem_wdata,
    output logic                     cpu_rst,
    output logic                     done
);

    // Chunk counter is at least one bit wide even if a word fits in one chunk.
    localparam int P_CW = (P_K > 1) ? $clog2(P_K) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;

    logic [P_CW-1:0]          r_chunkCnt;
    logic [P_IW-1:0]          r_assembly;
    logic [P_LOG_MEMSIZE-1:0] r_index;
    logic [P_LOG_MEMSIZE-1:0] r_lastIdx;

    logic                     r_inReady;
    logic                     r_memWe;
    logic                     r_cpuRst;
    logic                     r_done;

    logic                     w_handshake;
    logic                     w_lastChunk;
    logic                     w_lastWord;

    assign w_handshake = in_valid && r_inReady;
    assign w_lastChunk = (int'(r_chunkCnt) == P_K - 1);
    assign w_lastWord  = (r_index == r_lastIdx);

    assign in_ready  = r_inReady;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_index;
    assign mem_wdata = r_assembly;
    assign cpu_rst   = r_cpuRst;
    assign done      = r_done;

    // Next-state decode; start from any state aborts and restarts at LEN.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_nextState = S_LEN;
            end
            S_LEN: begin
                if (start)            w_nextState = S_LEN;
                else if (w_handshake) w_nextState = S_LOAD;
            end
            S_LOAD: begin
                if (start)                           w_nextState = S_LEN;
                else if (w_handshake && w_lastChunk) w_nextState = S_WRITE;
            end
            S_WRITE: begin
                if (start)           w_nextState = S_LEN;
                else if (w_lastWord) w_nextState = S_DONE;
                else                 w_nextState = S_LOAD;
            end
            S_DONE: begin
                if (start) w_nextState = S_LEN;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // State register and output flops, which are decoded from the next state
    // so every output comes straight from a flop and lines up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_inReady <= 1'b0;
            r_memWe   <= 1'b0;
            r_cpuRst  <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_inReady <= (w_nextState == S_LEN) || (w_nextState == S_LOAD);
            r_memWe   <= (w_nextState == S_WRITE);
            r_cpuRst  <= (w_nextState != S_DONE);
            r_done    <= (w_nextState == S_DONE);
        end
    end

    // Length capture, chunk assembly and write address stepping. A start in
    // the same cycle wins, so a partly built word is simply abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chunkCnt <= '0;
            r_assembly <= '0;
            r_index    <= '0;
            r_lastIdx  <= '0;
        end else if (!start) begin
            case (r_state)
                S_LEN: begin
                    if (w_handshake) begin
                        r_lastIdx  <= in_data[P_LOG_MEMSIZE-1:0];
                        r_index    <= '0;
                        r_chunkCnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_handshake) begin
                        for (int b = 0; b < P_IW; b++) begin
                            if (int'(r_chunkCnt) == b / P_IN_WIDTH) begin
                                r_assembly[b] <= in_data[b % P_IN_WIDTH];
                            end
                        end
                        r_chunkCnt <= w_lastChunk ? '0 : r_chunkCnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!w_lastWord) begin
                        r_index    <= r_index + 1'b1;
                        r_chunkCnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader. Expected writes are queued
// as stimulus is driven and checked whenever the DUT pulses mem_we.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [10:0] mem_wdata;
    logic        cpu_rst;
    logic        done;

    typedef struct packed {
        logic [3:0]  addr;
        logic [10:0] data;
    } wrEntry_t;

    wrEntry_t    expQ[$];
    wrEntry_t    monEntry;
    logic [10:0] progWords[$];
    int          checkCount = 0;
    int          failCount  = 0;

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Every write the DUT makes must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && mem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", {mem_addr, mem_wdata}, 32'h0);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("wr_addr", mem_addr, monEntry.addr);
                checkOutput("wr_data", mem_wdata, monEntry.data);
            end
        end
    end

    // Present one chunk after an optional random idle gap; returns #1 after
    // the handshake edge with in_valid still high.
    task automatic applyStimulus(input logic [3:0] chunk, input int maxGap);
        int gap;
        int waitCycles;
        gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_data    = chunk;
        in_valid   = 1'b1;
        waitCycles = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitCycles++;
            if (waitCycles > 100) begin
                checkOutput("ready_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int cycles;
        cycles = 0;
        while (done !== 1'b1 && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, done, 1);
        checkOutput({tag, "_cpurst"}, cpu_rst, 0);
        @(posedge clk);
        #1;
    endtask

    // Load every word in progWords, queuing expected writes as chunks go out.
    task automatic loadWords(input int maxGap);
        logic [11:0] wx;
        wrEntry_t    e;
        pulseStart();
        applyStimulus(4'(progWords.size() - 1), maxGap);
        for (int i = 0; i < progWords.size(); i++) begin
            wx = {1'b0, progWords[i]};
            for (int j = 0; j < 3; j++) begin
                if (j == 2) begin
                    e.addr = 4'(i);
                    e.data = progWords[i];
                    expQ.push_back(e);
                end
                applyStimulus(wx[j*4 +: 4], maxGap);
            end
        end
        in_valid = 1'b0;
    endtask

    // Safety net so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        wrEntry_t e;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;

        // Reset values while rst is held.
        #1;
        checkOutput("rst_cpu_rst", cpu_rst, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle with no start: chunks offered are ignored and the CPU stays held.
        in_valid = 1'b1;
        in_data  = 4'h5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("idle_state", {cpu_rst, done, in_ready, mem_we}, 4'b1000);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Single word 0x235, with write latency and done timing checked.
        $display("[TB] single word load");
        pulseStart();
        applyStimulus(4'h0, 0);
        applyStimulus(4'h5, 0);
        applyStimulus(4'h3, 0);
        e.addr = 4'h0;
        e.data = 11'h235;
        expQ.push_back(e);
        applyStimulus(4'h2, 0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("latency_we", mem_we, 1);
        checkOutput("latency_cpurst", cpu_rst, 1);
        @(negedge clk);
        checkOutput("single_done", done, 1);
        checkOutput("single_cpurst", cpu_rst, 0);
        checkOutput("single_we_low", mem_we, 0);
        @(posedge clk);
        #1;

        // Full memory: 16 words, data equals address; no wrap past 15.
        $display("[TB] full memory load");
        progWords.delete();
        for (int i = 0; i < 16; i++) progWords.push_back(11'(i));
        loadWords(0);
        waitDone("full_done");
        checkOutput("full_addr_hold", mem_addr, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("full_still_done", done, 1);

        // Random stalls on in_valid during a three-word load.
        $display("[TB] stalled load");
        progWords.delete();
        progWords.push_back(11'h7FF);
        progWords.push_back(11'h001);
        progWords.push_back(11'h400);
        loadWords(3);
        waitDone("stall_done");

        // Restart mid-load: second word abandoned, new load starts at addr 0.
        $display("[TB] restart during load");
        pulseStart();
        checkOutput("restart0_done_clr", done, 0);
        checkOutput("restart0_cpurst", cpu_rst, 1);
        applyStimulus(4'h2, 0);
        e.addr = 4'h0;
        e.data = 11'h017;
        applyStimulus(4'h7, 0);
        applyStimulus(4'h1, 0);
        expQ.push_back(e);
        applyStimulus(4'h0, 0);
        applyStimulus(4'hA, 0);
        applyStimulus(4'hB, 0);
        in_valid = 1'b0;
        pulseStart();
        checkOutput("restart_len_ready", in_ready, 1);
        checkOutput("restart_cpurst", cpu_rst, 1);
        applyStimulus(4'h0, 0);
        applyStimulus(4'h3, 0);
        applyStimulus(4'h2, 0);
        e.addr = 4'h0;
        e.data = 11'h123;
        expQ.push_back(e);
        applyStimulus(4'h9, 0);
        in_valid = 1'b0;
        waitDone("restart_done");

        // Async reset landing in a WRITE cycle.
        $display("[TB] async reset during write");
        pulseStart();
        applyStimulus(4'h1, 0);
        applyStimulus(4'h5, 0);
        applyStimulus(4'h5, 0);
        applyStimulus(4'h5, 0);
        in_valid = 1'b0;
        checkOutput("pre_rst_we", mem_we, 1);
        rst = 1'b1;
        #1;
        checkOutput("arst_mem_we", mem_we, 0);
        checkOutput("arst_cpu_rst", cpu_rst, 1);
        checkOutput("arst_in_ready", in_ready, 0);
        checkOutput("arst_mem_addr", mem_addr, 0);
        checkOutput("arst_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        progWords.delete();
        progWords.push_back(11'h3AA);
        progWords.push_back(11'h055);
        loadWords(1);
        waitDone("post_rst_done");

        checkOutput("queue_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
